// File: rtl/reg_bank_sequencer.sv
// Round-robin sequencer sharing a byte-wide register bank among NREQ requesters.
// Single-beat ops pass straight through; LOAD16 is split into a low-byte and a high-byte beat.
module reg_bank_sequencer #(
    parameter int NREQ = 4,
    parameter int NREG = 4,
    parameter int SELW = 2
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic [NREQ-1:0]      ReqValid,
    input  logic [3*NREQ-1:0]    ReqOp,
    input  logic [SELW*NREQ-1:0] ReqSel,
    input  logic [16*NREQ-1:0]   ReqData,
    output logic [NREQ-1:0]      ReqAck,
    output logic                 ReqErr,
    output logic [2:0]           FunSel,
    output logic [NREG-1:0]      E,
    output logic [15:0]          RegI,
    output logic                 Busy
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {IDLE, ONE, LO, HI} state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [PW-1:0]   gnt_q, gnt_d;
    logic [2:0]      op_q, op_d;
    logic [SELW-1:0] sel_q, sel_d;
    logic [15:0]     data_q, data_d;

    logic [NREQ-1:0] ack_q, ack_d;
    logic            err_q, err_d;
    logic [2:0]      funsel_q, funsel_d;
    logic [NREG-1:0] e_q, e_d;
    logic [15:0]     regi_q, regi_d;
    logic            busy_q, busy_d;

    logic            found;
    int              cand;
    int              idx;
    logic            in_range;
    logic [NREG-1:0] e_hot;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q  <= IDLE;
            ptr_q    <= PW'(NREQ - 1);
            gnt_q    <= '0;
            op_q     <= '0;
            sel_q    <= '0;
            data_q   <= '0;
            ack_q    <= '0;
            err_q    <= 1'b0;
            funsel_q <= '0;
            e_q      <= '0;
            regi_q   <= '0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            gnt_q    <= gnt_d;
            op_q     <= op_d;
            sel_q    <= sel_d;
            data_q   <= data_d;
            ack_q    <= ack_d;
            err_q    <= err_d;
            funsel_q <= funsel_d;
            e_q      <= e_d;
            regi_q   <= regi_d;
            busy_q   <= busy_d;
        end
    end

    // Grant search starts one past the last winner, so the last winner ranks lowest.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        op_d    = op_q;
        sel_d   = sel_q;
        data_d  = data_q;
        found   = 1'b0;
        cand    = 0;
        idx     = 0;
        case (state_q)
            IDLE: begin
                for (int k = 1; k <= NREQ; k++) begin
                    cand = int'(ptr_q) + k;
                    if (cand >= NREQ) cand = cand - NREQ;
                    if (!found && ReqValid[cand]) begin
                        found = 1'b1;
                        idx   = cand;
                    end
                end
                if (found) begin
                    gnt_d   = PW'(idx);
                    ptr_d   = PW'(idx);
                    op_d    = ReqOp[3*idx +: 3];
                    sel_d   = ReqSel[SELW*idx +: SELW];
                    data_d  = ReqData[16*idx +: 16];
                    state_d = (op_d == 3'd2) ? LO : ONE;
                end
            end
            ONE:     state_d = IDLE;
            LO:      state_d = HI;
            HI:      state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are computed from the next state so they appear registered in the beat itself.
    always_comb begin
        ack_d    = '0;
        err_d    = 1'b0;
        funsel_d = 3'b000;
        e_d      = '0;
        regi_d   = 16'h0000;
        busy_d   = (state_d != IDLE);
        in_range = (int'(sel_d) < NREG);
        for (int r = 0; r < NREG; r++) e_hot[r] = in_range && (int'(sel_d) == r);
        case (state_d)
            ONE: begin
                e_d        = e_hot;
                funsel_d   = op_d;
                regi_d     = op_d[2] ? {8'h00, data_d[7:0]} : 16'h0000;
                ack_d[gnt_d] = 1'b1;
                err_d      = !in_range;
            end
            LO: begin
                e_d      = e_hot;
                funsel_d = 3'b100;
                regi_d   = {8'h00, data_d[7:0]};
            end
            HI: begin
                e_d        = e_hot;
                funsel_d   = 3'b110;
                regi_d     = {8'h00, data_d[15:8]};
                ack_d[gnt_d] = 1'b1;
                err_d      = !in_range;
            end
            default: ;
        endcase
    end

    assign ReqAck = ack_q;
    assign ReqErr = err_q;
    assign FunSel = funsel_q;
    assign E      = e_q;
    assign RegI   = regi_q;
    assign Busy   = busy_q;

endmodule
